dbus_mem_responder: RTL and testbench



---
 rtl/dbus_pkg.sv | 24 ++
 rtl/dbus_mem_responder_if.sv | 35 +++
 rtl/dbus_ram.sv | 34 +++
 rtl/dbus_mem_responder.sv | 120 ++++++++++++
 tb/tb_dbus_mem_responder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared types and helpers for the dBus memory responder
// FSM state encoding and the access-size to burst-length mapping.
package dbus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int DBUS_WORD_BYTES = 4;
  localparam int DBUS_MAX_BEATS  = 8;

  // Sub-word and word accesses are one beat; a cache line is 2^size/4 beats.
  function automatic logic [3:0] dbus_beats(input logic [2:0] size);
    if (size <= 3'd2) begin
      return 4'd1;
    end else if (size >= 3'd5) begin
      return 4'(DBUS_MAX_BEATS);
    end else begin
      return 4'd1 << (size - 3'd2);
    end
  endfunction

endpackage

// File: rtl/dbus_mem_responder_if.sv
// rtl/dbus_mem_responder_if.sv - VexRiscv cached data bus command/response signals
// The core is the master; the memory responder is the slave.
interface dbus_mem_responder_if;

  logic        dBus_cmd_valid;
  logic        dBus_cmd_ready;
  logic        dBus_cmd_payload_wr;
  logic        dBus_cmd_payload_uncached;
  logic [31:0] dBus_cmd_payload_address;
  logic [31:0] dBus_cmd_payload_data;
  logic [3:0]  dBus_cmd_payload_mask;
  logic [2:0]  dBus_cmd_payload_size;
  logic        dBus_cmd_payload_last;
  logic        dBus_rsp_valid;
  logic        dBus_rsp_payload_last;
  logic [31:0] dBus_rsp_payload_data;
  logic        dBus_rsp_payload_error;

  modport master (
    output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_uncached,
           dBus_cmd_payload_address, dBus_cmd_payload_data, dBus_cmd_payload_mask,
           dBus_cmd_payload_size, dBus_cmd_payload_last,
    input  dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_payload_last,
           dBus_rsp_payload_data, dBus_rsp_payload_error
  );

  modport slave (
    input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_uncached,
           dBus_cmd_payload_address, dBus_cmd_payload_data, dBus_cmd_payload_mask,
           dBus_cmd_payload_size, dBus_cmd_payload_last,
    output dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_payload_last,
           dBus_rsp_payload_data, dBus_rsp_payload_error
  );

endinterface

// File: rtl/dbus_ram.sv
// rtl/dbus_ram.sv - single-port byte-enabled synchronous RAM
// One-cycle read latency; a write returns the merged new word on the same port.
module dbus_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] w_merged;

  always_comb begin
    w_merged = r_mem[i_addr];
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        w_merged[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= w_merged;
    end
    o_rdata <= i_we ? w_merged : r_mem[i_addr];
  end

endmodule

// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - dBus slave serving read bursts and masked writes from on-chip RAM
// DBUS_RESPONDER_ERROR_EN: flag out-of-window reads with error and drop out-of-window writes.
module dbus_mem_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_left;
  logic          r_rsp_valid, r_last, r_err;

  logic          w_accept, w_is_read, w_in_range, w_ram_we;
  logic [AW-1:0] w_cmd_idx, w_ram_addr;
  logic [31:0]   w_ram_q;
  logic [3:0]    w_beats;
  logic          w_unused;

  assign w_cmd_idx = bus.dBus_cmd_payload_address[AW+1:2];
  assign w_beats   = dbus_beats(bus.dBus_cmd_payload_size);
  assign w_unused  = ^{bus.dBus_cmd_payload_uncached, bus.dBus_cmd_payload_last,
                       bus.dBus_cmd_payload_address};

`ifdef DBUS_RESPONDER_ERROR_EN
  assign w_in_range = (bus.dBus_cmd_payload_address[31:AW+2] == BASE_ADDR[31:AW+2]);
`else
  assign w_in_range = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    bus.dBus_cmd_ready = 1'b0;
    w_accept           = 1'b0;
    w_ram_addr         = w_cmd_idx;
    w_ram_we           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.dBus_cmd_ready = !reset;
        w_accept           = bus.dBus_cmd_valid && !reset;
        w_ram_we           = w_accept && bus.dBus_cmd_payload_wr && w_in_range;
        if (w_accept && !bus.dBus_cmd_payload_wr) begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        w_ram_addr = r_idx;
        if (r_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_is_read = w_accept && !bus.dBus_cmd_payload_wr;

  // r_idx always points at the word to fetch for the beat after the one on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_left      <= '0;
    end else if (r_state == ST_IDLE) begin
      r_rsp_valid <= w_is_read;
      r_last      <= w_is_read && (w_beats == 4'd1);
      if (w_is_read) begin
        r_idx  <= w_cmd_idx + 1'b1;
        r_left <= w_beats - 4'd1;
        r_err  <= !w_in_range;
      end
    end else if (r_last) begin
      r_rsp_valid <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_idx  <= r_idx + 1'b1;
      r_left <= r_left - 4'd1;
      r_last <= (r_left == 4'd1);
    end
  end

  dbus_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (bus.dBus_cmd_payload_mask),
    .i_wdata (bus.dBus_cmd_payload_data),
    .o_rdata (w_ram_q)
  );

  assign bus.dBus_rsp_valid        = r_rsp_valid;
  assign bus.dBus_rsp_payload_last = r_rsp_valid && r_last;
  assign bus.dBus_rsp_payload_data = (r_rsp_valid && !r_err) ? w_ram_q : 32'h0;
`ifdef DBUS_RESPONDER_ERROR_EN
  assign bus.dBus_rsp_payload_error = r_rsp_valid && r_err;
`else
  assign bus.dBus_rsp_payload_error = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb/tb_dbus_mem_responder.sv - self-checking bench for dbus_mem_responder
// Queue-based memory model checked every cycle, plus literal expectations per test.
module tb_dbus_mem_responder;

  localparam int          MW   = 4096;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef DBUS_RESPONDER_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    bit          last;
    bit          err;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   chk_en = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int beats_seen = 0;

  logic [31:0] mem [MW];
  beat_t       q [$];
  logic [31:0] obs_data [$];
  bit          obs_last [$];
  bit          obs_err [$];

  dbus_mem_responder_if bus();

  dbus_mem_responder #(
    .MEM_WORDS (MW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", 32'(bus.dBus_cmd_ready), 32'(!reset && q.size() == 0));
      check("rsp_valid", 32'(bus.dBus_rsp_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        beat_t b;
        b = q.pop_front();
        check("rsp_data", bus.dBus_rsp_payload_data, b.data);
        check("rsp_last", 32'(bus.dBus_rsp_payload_last), 32'(b.last));
        check("rsp_error", 32'(bus.dBus_rsp_payload_error), 32'(b.err));
        obs_data.push_back(bus.dBus_rsp_payload_data);
        obs_last.push_back(bus.dBus_rsp_payload_last);
        obs_err.push_back(bus.dBus_rsp_payload_error);
        beats_seen++;
      end
    end
  end

  task automatic model_accept(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] mask, input logic [2:0] size);
    int          idx;
    int          n;
    logic [31:0] off;
    bit          in_range;
    beat_t       b;
    idx      = int'((addr >> 2) & 32'(MW - 1));
    off      = addr - BASE;
    in_range = off < 32'(4 * MW);
    if (wr) begin
      if (!ERR_EN || in_range) begin
        for (int k = 0; k < 4; k++) begin
          if (mask[k]) mem[idx][8*k +: 8] = data[8*k +: 8];
        end
      end
    end else begin
      n = (size <= 3'd2) ? 1 : (1 << (int'(size) - 2));
      for (int i = 0; i < n; i++) begin
        b.err  = ERR_EN && !in_range;
        b.data = b.err ? 32'h0 : mem[(idx + i) % MW];
        b.last = (i == n - 1);
        q.push_back(b);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    if (q.size() != 0) begin
      while (q.size() != 0 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 100) begin
        check("idle_timeout", 32'(q.size()), 32'd0);
        q.delete();
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [2:0] size);
    wait_idle();
    bus.dBus_cmd_valid            = 1'b1;
    bus.dBus_cmd_payload_wr       = wr;
    bus.dBus_cmd_payload_address  = addr;
    bus.dBus_cmd_payload_data     = data;
    bus.dBus_cmd_payload_mask     = mask;
    bus.dBus_cmd_payload_size     = size;
    bus.dBus_cmd_payload_last     = 1'b1;
    bus.dBus_cmd_payload_uncached = 1'b0;
    @(posedge clk);
    model_accept(wr, addr, data, mask, size);
    #1;
    bus.dBus_cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    do_cmd(1'b1, addr, data, mask, 3'd2);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] size);
    wait_idle();
    obs_data.delete();
    obs_last.delete();
    obs_err.delete();
    do_cmd(1'b0, addr, 32'h0, 4'h0, size);
    wait_idle();
  endtask

  initial begin
    int target;
    int n;
    bus.dBus_cmd_valid            = 1'b0;
    bus.dBus_cmd_payload_wr       = 1'b0;
    bus.dBus_cmd_payload_uncached = 1'b0;
    bus.dBus_cmd_payload_address  = 32'h0;
    bus.dBus_cmd_payload_data     = 32'h0;
    bus.dBus_cmd_payload_mask     = 4'h0;
    bus.dBus_cmd_payload_size     = 3'd0;
    bus.dBus_cmd_payload_last     = 1'b0;
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.dBus_cmd_ready), 32'd0);
    check("rst_valid", 32'(bus.dBus_rsp_valid), 32'd0);
    check("rst_last", 32'(bus.dBus_rsp_payload_last), 32'd0);
    check("rst_data", bus.dBus_rsp_payload_data, 32'h0);
    check("rst_error", 32'(bus.dBus_rsp_payload_error), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rel_ready", 32'(bus.dBus_cmd_ready), 32'd1);
    check("rel_valid", 32'(bus.dBus_rsp_valid), 32'd0);

    wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    rd(32'h8000_0010, 3'd2);
    check("word_beats", 32'(obs_data.size()), 32'd1);
    check("word_data", obs_data[0], 32'hDEAD_BEEF);
    check("word_last", 32'(obs_last[0]), 32'd1);
    rd(32'h8000_0010, 3'd0);
    check("byte_data", obs_data[0], 32'hDEAD_BEEF);

    wr(32'h8000_0020, 32'h1122_3344, 4'hF);
    wr(32'h8000_0020, 32'h0000_00AA, 4'b0001);
    rd(32'h8000_0020, 3'd2);
    check("mask_data", obs_data[0], 32'h1122_33AA);
    wr(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000);
    rd(32'h8000_0020, 3'd2);
    check("mask0_data", obs_data[0], 32'h1122_33AA);

    for (int i = 0; i < 8; i++) wr(BASE + 32'(4 * i), 32'(i), 4'hF);
    rd(BASE, 3'd5);
    check("line_beats", 32'(obs_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("line_data", obs_data[i], 32'(i));
      check("line_last", 32'(obs_last[i]), 32'(i == 7));
    end
    rd(BASE + 32'h8, 3'd3);
    check("pair_beats", 32'(obs_data.size()), 32'd2);
    check("pair_data1", obs_data[1], 32'd3);

    for (int k = 0; k < 4; k++) wr(BASE + 32'(4 * (MW - 4 + k)), 32'h100 + 32'(k), 4'hF);
    rd(BASE + 32'(4 * (MW - 4)), 3'd5);
    check("wrap_beats", 32'(obs_data.size()), 32'd8);
    check("wrap_b0", obs_data[0], 32'h100);
    check("wrap_b3", obs_data[3], 32'h103);
    check("wrap_b4", obs_data[4], 32'd0);
    check("wrap_b7", obs_data[7], 32'd3);

    wait_idle();
    obs_data.delete();
    target = beats_seen + 3;
    do_cmd(1'b0, BASE + 32'(4 * (MW - 4)), 32'h0, 4'h0, 3'd5);
    n = 0;
    while (beats_seen < target && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_seen", 32'(beats_seen), 32'(target));
    reset = 1'b1;
    q.delete();
    #1;
    check("abort_valid", 32'(bus.dBus_rsp_valid), 32'd0);
    check("abort_ready", 32'(bus.dBus_cmd_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("abort_rel_ready", 32'(bus.dBus_cmd_ready), 32'd1);
    check("abort_rel_valid", 32'(bus.dBus_rsp_valid), 32'd0);
    check("abort_beats", 32'(obs_data.size()), 32'd3);

    wr(BASE, 32'hCAFE_0000, 4'hF);
    rd(32'h0000_0000, 3'd2);
    check("alias_data", obs_data[0], ERR_EN ? 32'h0 : 32'hCAFE_0000);
    check("alias_err", 32'(obs_err[0]), 32'(ERR_EN));
    check("alias_last", 32'(obs_last[0]), 32'd1);
    wr(32'h0000_0004, 32'h0000_0055, 4'hF);
    rd(BASE + 32'h4, 3'd2);
    check("oor_write", obs_data[0], ERR_EN ? 32'd1 : 32'h55);

    wait_idle();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
